multi_servo_ctrl: RTL and testbench

MULTI_SERVO_CTRL -- requirements
Module: multi_servo_ctrl

---
 rtl/servo_pkg.sv | 22 ++
 rtl/servo_pwm_channel.sv | 52 +++++
 rtl/multi_servo_ctrl.sv | 139 +++++++++++++
 tb/tb_multi_servo_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and types for the multi-channel servo controller.
// Latency: n/a (package only).
// Backpressure: n/a.
package servo_pkg;

  // PS/2 set-2 scan codes understood by the key decoder
  localparam logic [7:0] SC_BREAK = 8'hF0;  // release prefix
  localparam logic [7:0] SC_SEL0  = 8'h16;  // '1'
  localparam logic [7:0] SC_SEL1  = 8'h1E;  // '2'
  localparam logic [7:0] SC_SEL2  = 8'h26;  // '3'
  localparam logic [7:0] SC_SEL3  = 8'h25;  // '4'
  localparam logic [7:0] SC_DEC   = 8'h1C;  // 'A' : narrower pulse
  localparam logic [7:0] SC_INC   = 8'h23;  // 'D' : wider pulse
  localparam logic [7:0] SC_CTR   = 8'h1B;  // 'S' : recenter

  // Key decoder state: BREAK swallows the byte that follows 0xF0
  typedef enum logic {
    DEC_IDLE  = 1'b0,
    DEC_BREAK = 1'b1
  } dec_state_e;

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo output: holds the pulse width and compares it against the frame counter.
// Latency: pos follows tgt at frame_start (instantly, or slewed when SERVO_SLEW_EN is defined).
// Backpressure: none; tgt is sampled only in the frame_start cycle.
module servo_pwm_channel #(
  parameter int W       = 15,
`ifdef SERVO_SLEW_EN
  parameter int SLEW_US = 10,
`endif
  parameter int CENTER  = 1500
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         frame_start_i,
  input  logic [W-1:0] us_cnt_i,
  input  logic [W-1:0] tgt_i,
  output logic         pwm_o
);

  logic [W-1:0] pos_q;
  logic [W-1:0] pos_d;

`ifdef SERVO_SLEW_EN
  localparam logic [W-1:0] SLEW = W'(SLEW_US);

  // Step toward the target by at most SLEW; subtract only in the known-positive direction
  always_comb begin
    pos_d = pos_q;
    if (tgt_i > pos_q) begin
      if ((tgt_i - pos_q) > SLEW) pos_d = pos_q + SLEW;
      else                        pos_d = tgt_i;
    end else if (pos_q > tgt_i) begin
      if ((pos_q - tgt_i) > SLEW) pos_d = pos_q - SLEW;
      else                        pos_d = tgt_i;
    end
  end
`else
  // Without slew limiting the new frame jumps straight to the target
  always_comb begin
    pos_d = tgt_i;
  end
`endif

  // Width only changes on the frame boundary so a pulse is never cut or stretched mid-way
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              pos_q <= W'(CENTER);
    else if (frame_start_i) pos_q <= pos_d;
  end

  // Reset gates the output directly so an in-flight pulse drops in the same cycle
  assign pwm_o = (us_cnt_i < pos_q) & ~reset;

endmodule

// File: rtl/multi_servo_ctrl.sv
// PS/2-keyboard driven PWM controller for up to four hobby servos (optional slew: SERVO_SLEW_EN).
// Latency: key effects visible the cycle after check; pulse width changes at the next frame_start.
// Backpressure: none; every check strobe is consumed in its own cycle.
module multi_servo_ctrl
  import servo_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CLK_HZ   = 25000000,
  parameter int FRAME_US = 20000,
  parameter int MIN_US   = 1000,
  parameter int MAX_US   = 2000,
  parameter int STEP_US  = 50,
  parameter int SLEW_US  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              check,
  input  logic [7:0]        scan,
  output logic [NUM_CH-1:0] servo_pwm,
  output logic [1:0]        sel_ch,
  output logic              frame_start
);

  localparam int DIV    = CLK_HZ / 1000000;
  localparam int PW     = $clog2(DIV);
  localparam int W      = $clog2(FRAME_US);
  localparam int CENTER = (MIN_US + MAX_US) / 2;

  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [W-1:0]  CNT_LAST = W'(FRAME_US - 1);
  localparam logic [W-1:0]  MIN_V    = W'(MIN_US);
  localparam logic [W-1:0]  MAX_V    = W'(MAX_US);
  localparam logic [W-1:0]  CTR_V    = W'(CENTER);
  localparam logic [W-1:0]  STEP_V   = W'(STEP_US);

  logic [PW-1:0] pre_q;
  logic [W-1:0]  us_cnt_q;
  logic          tick;

  dec_state_e    state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [W-1:0]  tgt_q [NUM_CH];
  logic [W-1:0]  tgt_d [NUM_CH];

  // Saturating decrement, compared in 32 bits so the subtraction never wraps
  function automatic logic [W-1:0] tgt_dn(input logic [W-1:0] v);
    if (int'(v) < MIN_US + STEP_US) tgt_dn = MIN_V;
    else                            tgt_dn = v - STEP_V;
  endfunction

  // Saturating increment, compared in 32 bits so the addition never overflows W
  function automatic logic [W-1:0] tgt_up(input logic [W-1:0] v);
    if (int'(v) + STEP_US > MAX_US) tgt_up = MAX_V;
    else                            tgt_up = v + STEP_V;
  endfunction

  assign tick        = (pre_q == PRE_LAST);
  assign frame_start = tick && (us_cnt_q == CNT_LAST);
  assign sel_ch      = sel_q;

  // Prescaler: one tick per microsecond
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + 1'b1;
  end

  // Frame counter in microseconds, wrapping at the frame period
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            us_cnt_q <= '0;
    else if (frame_start) us_cnt_q <= '0;
    else if (tick)        us_cnt_q <= us_cnt_q + 1'b1;
  end

  // Key decoder next state: channel select, target nudges and break-code skipping
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    tgt_d   = tgt_q;
    if (check) begin
      unique case (state_q)
        DEC_BREAK: state_d = DEC_IDLE;
        DEC_IDLE: begin
          case (scan)
            SC_BREAK: state_d = DEC_BREAK;
            SC_SEL0:  sel_d = 2'd0;
            SC_SEL1:  if (NUM_CH > 1) sel_d = 2'd1;
            SC_SEL2:  if (NUM_CH > 2) sel_d = 2'd2;
            SC_SEL3:  if (NUM_CH > 3) sel_d = 2'd3;
            SC_DEC: begin
              for (int i = 0; i < NUM_CH; i++)
                if (sel_q == 2'(i)) tgt_d[i] = tgt_dn(tgt_q[i]);
            end
            SC_INC: begin
              for (int i = 0; i < NUM_CH; i++)
                if (sel_q == 2'(i)) tgt_d[i] = tgt_up(tgt_q[i]);
            end
            SC_CTR: begin
              for (int i = 0; i < NUM_CH; i++)
                if (sel_q == 2'(i)) tgt_d[i] = CTR_V;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  // Decoder, selection and target registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DEC_IDLE;
      sel_q   <= 2'd0;
      for (int i = 0; i < NUM_CH; i++) tgt_q[i] <= CTR_V;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    servo_pwm_channel #(
      .W       (W),
`ifdef SERVO_SLEW_EN
      .SLEW_US (SLEW_US),
`endif
      .CENTER  (CENTER)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .frame_start_i (frame_start),
      .us_cnt_i      (us_cnt_q),
      .tgt_i         (tgt_q[g]),
      .pwm_o         (servo_pwm[g])
    );
  end

endmodule

// File: tb/tb_multi_servo_ctrl.sv
// Bench for multi_servo_ctrl: time-scaled parameters (2 clk/us, 400 us frame, 100..200 us pulses).
// Latency: widths are measured per frame by a monitor and compared against hand-computed tables.
// Backpressure: n/a; keys are one-cycle strobes.
module tb_multi_servo_ctrl;

  localparam int DIV   = 2;
  localparam int FRAME = 400;
  localparam int FCYC  = FRAME * DIV;
`ifdef SERVO_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       check;
  logic [7:0] scan;
  logic [3:0] servo_pwm;
  logic [1:0] sel_ch;
  logic       frame_start;
  logic [1:0] servo_pwm2;
  logic [1:0] sel_ch2;
  logic       frame_start2;

  multi_servo_ctrl #(
    .NUM_CH(4), .CLK_HZ(2000000), .FRAME_US(FRAME), .MIN_US(100), .MAX_US(200),
    .STEP_US(5), .SLEW_US(200)
  ) dut (
    .clk(clk), .reset(reset), .check(check), .scan(scan),
    .servo_pwm(servo_pwm), .sel_ch(sel_ch), .frame_start(frame_start)
  );

  multi_servo_ctrl #(
    .NUM_CH(2), .CLK_HZ(2000000), .FRAME_US(FRAME), .MIN_US(100), .MAX_US(200),
    .STEP_US(5), .SLEW_US(1)
  ) dut2 (
    .clk(clk), .reset(reset), .check(check), .scan(scan),
    .servo_pwm(servo_pwm2), .sel_ch(sel_ch2), .frame_start(frame_start2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Per-frame pulse-width monitor (in clk cycles)
  int acc [4];
  int acc2 [2];
  int last_w [4];
  int last_w2 [2];
  int cyc = 0;
  int last_len = 0;
  int frame_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) acc[i] = 0;
      for (int i = 0; i < 2; i++) acc2[i] = 0;
      cyc = 0;
    end else begin
      for (int i = 0; i < 4; i++) acc[i] += int'(servo_pwm[i]);
      for (int i = 0; i < 2; i++) acc2[i] += int'(servo_pwm2[i]);
      cyc++;
      if (frame_start) begin
        for (int i = 0; i < 4; i++) begin last_w[i] = acc[i]; acc[i] = 0; end
        for (int i = 0; i < 2; i++) begin last_w2[i] = acc2[i]; acc2[i] = 0; end
        last_len = cyc;
        cyc = 0;
        frame_cnt++;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_key(input logic [7:0] b);
    @(posedge clk); #1;
    check = 1'b1;
    scan  = b;
    @(posedge clk); #1;
    check = 1'b0;
    scan  = 8'h00;
  endtask

  // Returns at the first posedge after the monitor has recorded a new frame
  task automatic wait_fs();
    int start;
    bit seen;
    start = frame_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 2 * FCYC; i++) begin
      @(posedge clk);
      if (frame_cnt != start) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_err++;
      $display("FAIL wait_fs: no frame_start within %0d cycles", 2 * FCYC);
    end
  endtask

  typedef struct {
    logic [7:0] scan;
    int         reps;
    int         sel;
    int         sel2;
    int         w0, w1, w2, w3;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    // scan, reps, sel, sel(NUM_CH=2), widths after (us)
    vecs[0]  = '{8'h23, 1,  0, 0, 155, 150, 150, 150};
    vecs[1]  = '{8'h1E, 1,  1, 1, 155, 150, 150, 150};
    vecs[2]  = '{8'h1C, 2,  1, 1, 155, 140, 150, 150};
    vecs[3]  = '{8'h26, 1,  2, 1, 155, 140, 150, 150};
    vecs[4]  = '{8'h23, 30, 2, 1, 155, 140, 200, 150};
    vecs[5]  = '{8'h25, 1,  3, 1, 155, 140, 200, 150};
    vecs[6]  = '{8'h1C, 30, 3, 1, 155, 140, 200, 100};
    vecs[7]  = '{8'h1B, 1,  3, 1, 155, 140, 200, 150};
    vecs[8]  = '{8'hF0, 1,  3, 1, 155, 140, 200, 150};
    vecs[9]  = '{8'h23, 1,  3, 1, 155, 140, 200, 150};
    vecs[10] = '{8'h23, 1,  3, 1, 155, 140, 200, 155};
    vecs[11] = '{8'h16, 1,  0, 0, 155, 140, 200, 155};
    vecs[12] = '{8'h1C, 30, 0, 0, 100, 140, 200, 155};
    vecs[13] = '{8'h00, 1,  0, 0, 100, 140, 200, 155};
    vecs[14] = '{8'hF0, 1,  0, 0, 100, 140, 200, 155};
    vecs[15] = '{8'h1E, 1,  0, 0, 100, 140, 200, 155};

    reset = 1'b1;
    check = 1'b0;
    scan  = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    chk("reset pwm", int'(servo_pwm), 0);
    chk("reset pwm2", int'(servo_pwm2), 0);
    chk("reset frame_start", int'(frame_start), 0);
    chk("reset sel", int'(sel_ch), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle frames after reset: center width, full frame period
    for (int f = 0; f < 3; f++) begin
      wait_fs();
      chk($sformatf("idle f%0d len", f), last_len, FCYC);
      for (int i = 0; i < 4; i++) chk($sformatf("idle f%0d w%0d", f, i), last_w[i], 150 * DIV);
      for (int i = 0; i < 2; i++) chk($sformatf("idle f%0d dut2 w%0d", f, i), last_w2[i], 150 * DIV);
    end

    // Key vectors
    for (int v = 0; v < NV; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) send_key(vecs[v].scan);
      wait_fs();
      wait_fs();
      @(negedge clk);
      chk($sformatf("v%0d sel", v), int'(sel_ch), vecs[v].sel);
      chk($sformatf("v%0d sel2", v), int'(sel_ch2), vecs[v].sel2);
      chk($sformatf("v%0d w0", v), last_w[0], vecs[v].w0 * DIV);
      chk($sformatf("v%0d w1", v), last_w[1], vecs[v].w1 * DIV);
      chk($sformatf("v%0d w2", v), last_w[2], vecs[v].w2 * DIV);
      chk($sformatf("v%0d w3", v), last_w[3], vecs[v].w3 * DIV);
    end

    // Key strobe in the frame_start cycle: old target for one more frame
    wait_fs();
    repeat (FCYC - 1) @(posedge clk);
    #1;
    check = 1'b1;
    scan  = 8'h23;
    @(negedge clk);
    chk("coincident frame_start", int'(frame_start), 1);
    @(posedge clk); #1;
    check = 1'b0;
    scan  = 8'h00;
    wait_fs();
    chk("coincident old w0", last_w[0], 100 * DIV);
    wait_fs();
    chk("coincident new w0", last_w[0], 105 * DIV);

    // Reset in the middle of a pulse
    wait_fs();
    repeat (20) @(posedge clk);
    #1;
    chk("pre-reset pwm0", int'(servo_pwm[0]), 1);
    reset = 1'b1;
    #1;
    chk("mid-pulse reset pwm", int'(servo_pwm), 0);
    chk("mid-pulse reset pwm2", int'(servo_pwm2), 0);
    chk("mid-pulse reset frame_start", int'(frame_start), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("mid-pulse reset sel", int'(sel_ch), 0);
    reset = 1'b0;
    wait_fs();
    chk("post-reset len", last_len, FCYC);
    for (int i = 0; i < 4; i++) chk($sformatf("post-reset w%0d", i), last_w[i], 150 * DIV);
    for (int i = 0; i < 2; i++) chk($sformatf("post-reset dut2 w%0d", i), last_w2[i], 150 * DIV);

    // Channel 1 to 170 us: immediate on the fast-slew instance, 1 us per frame on dut2 when slewing
    send_key(8'h1E);
    for (int r = 0; r < 4; r++) send_key(8'h23);
    wait_fs();
    for (int k = 1; k <= 20; k++) begin
      wait_fs();
      chk($sformatf("slew k%0d dut2 w1", k), last_w2[1], (SLEW_ON ? 150 + k : 170) * DIV);
      chk($sformatf("slew k%0d dut2 w0", k), last_w2[0], 150 * DIV);
      chk($sformatf("slew k%0d w1", k), last_w[1], 170 * DIV);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
